fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_if.sv | 24 ++
 rtl/fifo_reader.sv | 97 +++++++++
 tb/tb_fifo_reader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_if.sv
// Handshake bundle between fifo_reader, the FIFO it pops from and the downstream consumer.
interface fifo_reader_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             en_i;
    logic             fifo_empty_i;
    logic [WIDTH-1:0] fifo_data_i;
    logic             fifo_rd_en_o;
    logic             m_valid_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_ready_i;
    logic [CNT_W-1:0] count_o;

    modport slave (
        input  en_i, fifo_empty_i, fifo_data_i, m_ready_i,
        output fifo_rd_en_o, m_valid_o, m_data_o, count_o
    );

    modport master (
        output en_i, fifo_empty_i, fifo_data_i, m_ready_i,
        input  fifo_rd_en_o, m_valid_o, m_data_o, count_o
    );
endinterface

// File: rtl/fifo_reader.sv
// Pops a one-cycle-latency FIFO into a 2-entry skid buffer and presents words on a
// valid/ready stream, counting accepted words.
module fifo_reader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic           clk_i,
    input logic           rst_i,
    fifo_reader_if.slave  bus
);
    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_t;

    occ_t             occ, occ_next;
    logic             pend;
    logic             run;
    logic             xfer;
    logic             rd_en;
    logic [2:0]       fill;
    logic [WIDTH-1:0] head, head_next;
    logic [WIDTH-1:0] tail, tail_next;
    logic [CNT_W-1:0] count;

    assign xfer = (occ != OCC_0) && bus.m_ready_i;

    // Slots committed after this edge: buffered plus in-flight, minus the word leaving now.
    assign fill  = {1'b0, occ} + {2'b00, pend} - {2'b00, xfer};
    // run holds reads off until the first edge after reset release.
    assign rd_en = run && bus.en_i && !bus.fifo_empty_i && (fill < 3'd2);

    always_comb begin
        occ_next  = occ;
        head_next = head;
        tail_next = tail;
        case (occ)
            OCC_0: begin
                if (pend) begin
                    head_next = bus.fifo_data_i;
                    occ_next  = OCC_1;
                end
            end
            OCC_1: begin
                case ({xfer, pend})
                    2'b10: occ_next = OCC_0;
                    2'b01: begin
                        tail_next = bus.fifo_data_i;
                        occ_next  = OCC_2;
                    end
                    2'b11: head_next = bus.fifo_data_i;
                    default: ;
                endcase
            end
            OCC_2: begin
                case ({xfer, pend})
                    2'b10: begin
                        head_next = tail;
                        occ_next  = OCC_1;
                    end
                    2'b11: begin
                        head_next = tail;
                        tail_next = bus.fifo_data_i;
                    end
                    default: ;
                endcase
            end
            default: occ_next = OCC_0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            occ   <= OCC_0;
            pend  <= 1'b0;
            run   <= 1'b0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            occ   <= occ_next;
            pend  <= rd_en;
            run   <= 1'b1;
            head  <= head_next;
            tail  <= tail_next;
            if (xfer) begin
                count <= count + 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en_o = rd_en;
    assign bus.m_valid_o    = (occ != OCC_0);
    assign bus.m_data_o     = head;
    assign bus.count_o      = count;
endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a queue-backed FIFO model feeds the DUT, a monitor collects accepted words.
module tb_fifo_reader;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic rst_i;

    fifo_reader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    fifo_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc, nreads, bad_reads, stab_err, first_rd, first_valid;
    logic block_empty = 1'b0;
    logic prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] rx[$];
    int rx_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_empty();
        bus.fifo_empty_i = (fq.size() == 0) || block_empty;
    endtask

    // One clock: sample mid-cycle, then advance the FIFO model just after the edge.
    task automatic cycle();
        logic rd;
        #2;
        rd = bus.fifo_rd_en_o;
        if (rd) begin
            nreads++;
            if (first_rd < 0) first_rd = cyc;
            if (bus.fifo_empty_i) bad_reads++;
        end
        if (bus.m_valid_o && first_valid < 0) first_valid = cyc;
        if (prev_hold && (!bus.m_valid_o || bus.m_data_o !== prev_data)) stab_err++;
        prev_hold = bus.m_valid_o && !bus.m_ready_i;
        prev_data = bus.m_data_o;
        if (bus.m_valid_o && bus.m_ready_i) begin
            rx.push_back(bus.m_data_o);
            rx_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rd && fq.size() > 0) bus.fifo_data_i = fq.pop_front();
        else bus.fifo_data_i = '0;
        set_empty();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_stats();
        rx.delete();
        rx_cyc.delete();
        cyc = 0;
        nreads = 0;
        bad_reads = 0;
        stab_err = 0;
        first_rd = -1;
        first_valid = -1;
        prev_hold = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        bus.en_i = 1'b0;
        bus.m_ready_i = 1'b0;
        block_empty = 1'b0;
        fq.delete();
        bus.fifo_data_i = '0;
        set_empty();
        prev_hold = 1'b0;
        run(2);
        rst_i = 1'b1;
        clear_stats();
    endtask

    task automatic load(input logic [WIDTH-1:0] base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(base + WIDTH'(i));
        set_empty();
    endtask

    task automatic check_stream(input string tag, input logic [WIDTH-1:0] base, input int n);
        check({tag, "_size"}, 64'(rx.size()), 64'(n));
        for (int i = 0; i < n && i < rx.size(); i++)
            check(tag, 64'(rx[i]), 64'(base + WIDTH'(i)));
    endtask

    task automatic check_back_to_back(input string tag);
        for (int i = 1; i < rx_cyc.size(); i++)
            check(tag, 64'(rx_cyc[i]), 64'(rx_cyc[0] + i));
    endtask

    initial begin
        clear_stats();
        // Reset held with the FIFO non-empty and enable high
        rst_i = 1'b0;
        bus.en_i = 1'b1;
        bus.m_ready_i = 1'b1;
        bus.fifo_data_i = '0;
        load(32'h55, 3);
        #1;
        check("rst_valid", 64'(bus.m_valid_o), 64'd0);
        check("rst_data", 64'(bus.m_data_o), 64'd0);
        check("rst_count", 64'(bus.count_o), 64'd0);
        check("rst_rd_en", 64'(bus.fifo_rd_en_o), 64'd0);

        // Three-word stream, ready held high
        do_reset();
        load(32'hA1, 3);
        bus.en_i = 1'b1;
        bus.m_ready_i = 1'b1;
        #1;
        check("rd_before_edge", 64'(bus.fifo_rd_en_o), 64'd0);
        run(8);
        check_stream("s1_word", 32'hA1, 3);
        check_back_to_back("s1_consec");
        check("s1_first_rd", 64'(first_rd), 64'd1);
        check("s1_latency", 64'(first_valid - first_rd), 64'd2);
        check("s1_count", 64'(bus.count_o), 64'd3);
        check("s1_idle_valid", 64'(bus.m_valid_o), 64'd0);

        // Backpressure: only two reads issued, then drain all five with no gaps
        do_reset();
        load(32'hB0, 5);
        bus.en_i = 1'b1;
        run(6);
        check("s2_reads", 64'(nreads), 64'd2);
        check("s2_valid", 64'(bus.m_valid_o), 64'd1);
        check("s2_head", 64'(bus.m_data_o), 64'hB0);
        check("s2_rd_held", 64'(bus.fifo_rd_en_o), 64'd0);
        check("s2_stable", 64'(stab_err), 64'd0);
        bus.m_ready_i = 1'b1;
        run(8);
        check_stream("s2_word", 32'hB0, 5);
        check_back_to_back("s2_consec");
        check("s2_count", 64'(bus.count_o), 64'd5);

        // Ready toggling over a ten-word stream
        do_reset();
        load(32'hC0, 10);
        bus.en_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.m_ready_i = (i % 2 == 0);
            cycle();
        end
        check_stream("s3_word", 32'hC0, 10);
        check("s3_stable", 64'(stab_err), 64'd0);
        check("s3_count", 64'(bus.count_o), 64'd10);

        // Enable dropped while the first read is in flight
        do_reset();
        load(32'hD0, 4);
        bus.en_i = 1'b1;
        run(2);
        bus.en_i = 1'b0;
        bus.m_ready_i = 1'b1;
        run(5);
        check("s4_reads", 64'(nreads), 64'd1);
        check_stream("s4_inflight", 32'hD0, 1);
        check("s4_count", 64'(bus.count_o), 64'd1);
        check("s4_rd_off", 64'(bus.fifo_rd_en_o), 64'd0);
        bus.en_i = 1'b1;
        run(8);
        check_stream("s4_word", 32'hD0, 4);

        // Empty flag toggling every cycle; fifo_data reads zero when not popped
        do_reset();
        load(32'hE0, 6);
        bus.en_i = 1'b1;
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 24; i++) begin
            block_empty = (i % 2 == 1);
            set_empty();
            cycle();
        end
        check("s5_bad_reads", 64'(bad_reads), 64'd0);
        check_stream("s5_word", 32'hE0, 6);
        check("s5_count", 64'(bus.count_o), 64'd6);

        // Mid-stream reset with a full buffer, then 17 transfers on a 4-bit counter
        do_reset();
        load(32'h100, 21);
        bus.en_i = 1'b1;
        bus.m_ready_i = 1'b1;
        run(5);
        bus.m_ready_i = 1'b0;
        run(3);
        check("s6_pre_count", 64'(bus.count_o), 64'd2);
        check("s6_pre_head", 64'(bus.m_data_o), 64'h102);
        check("s6_pre_rd", 64'(bus.fifo_rd_en_o), 64'd0);
        rst_i = 1'b0;
        prev_hold = 1'b0;
        #1;
        check("s6_rst_valid", 64'(bus.m_valid_o), 64'd0);
        check("s6_rst_data", 64'(bus.m_data_o), 64'd0);
        check("s6_rst_count", 64'(bus.count_o), 64'd0);
        check("s6_rst_rd", 64'(bus.fifo_rd_en_o), 64'd0);
        run(2);
        rst_i = 1'b1;
        clear_stats();
        bus.m_ready_i = 1'b1;
        run(30);
        check_stream("s6_word", 32'h104, 17);
        check("s6_count_wrap", 64'(bus.count_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
